kbd_scan_decoder: RTL and testbench

KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

---
 rtl/kbd_pkg.sv | 32 +++
 rtl/scan2ascii.sv | 57 +++++
 rtl/kbd_scan_decoder.sv | 136 +++++++++++++
 tb/tb_kbd_scan_decoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 scan-code decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kbd_pkg;

  // One set-2 scan-code byte as delivered by the PS/2 receiver.
  typedef logic [7:0] scan_code_t;

  // Byte-handling sequence: take one byte, wait for the FIFO head to settle,
  // then interpret the byte.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_DECODE = 2'd2
  } kbd_state_e;

  // Prefix bytes: extended-key marker and break (release) marker.
  localparam scan_code_t SC_EXT = 8'hE0;
  localparam scan_code_t SC_BRK = 8'hF0;

  // ASCII value reported for keys without a printable mapping.
  localparam logic [7:0] ASCII_NONE = 8'h00;

  // Everything known about the key currently (or most recently) held.
  typedef struct packed {
    scan_code_t code;
    logic       ext;
    logic [7:0] ascii;
    logic       valid;
  } held_key_t;

endpackage

// File: rtl/scan2ascii.sv
// Set-2 scan code to ASCII lookup: lowercase letters, digits, space, enter.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input code.
module scan2ascii
  import kbd_pkg::*;
(
  input  scan_code_t code,
  output logic [7:0] ascii
);

  // Fixed lookup table; anything not listed has no printable meaning.
  always_comb begin
    ascii = ASCII_NONE;
    case (code)
      8'h1C: ascii = 8'h61; // a
      8'h32: ascii = 8'h62; // b
      8'h21: ascii = 8'h63; // c
      8'h23: ascii = 8'h64; // d
      8'h24: ascii = 8'h65; // e
      8'h2B: ascii = 8'h66; // f
      8'h34: ascii = 8'h67; // g
      8'h33: ascii = 8'h68; // h
      8'h43: ascii = 8'h69; // i
      8'h3B: ascii = 8'h6A; // j
      8'h42: ascii = 8'h6B; // k
      8'h4B: ascii = 8'h6C; // l
      8'h3A: ascii = 8'h6D; // m
      8'h31: ascii = 8'h6E; // n
      8'h44: ascii = 8'h6F; // o
      8'h4D: ascii = 8'h70; // p
      8'h15: ascii = 8'h71; // q
      8'h2D: ascii = 8'h72; // r
      8'h1B: ascii = 8'h73; // s
      8'h2C: ascii = 8'h74; // t
      8'h3C: ascii = 8'h75; // u
      8'h2A: ascii = 8'h76; // v
      8'h1D: ascii = 8'h77; // w
      8'h22: ascii = 8'h78; // x
      8'h35: ascii = 8'h79; // y
      8'h1A: ascii = 8'h7A; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      8'h5A: ascii = 8'h0D; // enter
      default: ascii = ASCII_NONE;
    endcase
  end

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-code decoder: pops bytes from the receive FIFO and tracks the held key.
// Latency: one byte every 3 cycles minimum; key outputs update at the end of DECODE.
// Backpressure: pops only while kb_ready is high and only from IDLE; POP cycle guards double pop.
module kbd_scan_decoder
  import kbd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic [7:0] key_ascii,
  output logic       key_valid,
  output logic       new_key,
  output logic [7:0] press_count,
  output logic       err_ovf
);

  kbd_state_e state_q, state_d;
  scan_code_t byte_q, byte_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  held_key_t  held_q, held_d;
  logic       new_key_q, new_key_d;
  logic [7:0] press_count_q, press_count_d;
  logic       err_ovf_q, err_ovf_d;

  logic [7:0] ascii_lkp;
  logic       same_key;
  logic       pop;

  scan2ascii u_scan2ascii (
    .code  (byte_q),
    .ascii (ascii_lkp)
  );

  // The FIFO head is consumed in the same IDLE cycle it is latched; reset
  // masks the strobe so nothing is popped while the decoder is held.
  assign pop           = (state_q == ST_IDLE) && kb_ready;
  assign kb_nextdata_n = ~pop | rst;

  // A byte matches the held key only if both the code and the E0 flag agree.
  assign same_key = held_q.valid && (byte_q == held_q.code) && (ext_q == held_q.ext);

  // Next-state logic: byte intake, prefix tracking and make/break interpretation.
  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    held_d        = held_q;
    new_key_d     = 1'b0;
    press_count_d = press_count_q;
    err_ovf_d     = err_ovf_q | kb_overflow;

    case (state_q)
      ST_IDLE: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          state_d = ST_POP;
        end
      end

      // kb_ready may still reflect the popped byte here, so ignore it.
      ST_POP: begin
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = ST_IDLE;
        if (byte_q == SC_EXT) begin
          ext_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_d = 1'b1;
        end else if (brk_q) begin
          // Release of anything other than the held key is ignored.
          if (same_key) begin
            held_d.valid = 1'b0;
          end
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          // Typematic repeats of the held key are silent.
          if (!same_key) begin
            held_d.code   = byte_q;
            held_d.ext    = ext_q;
            held_d.ascii  = ext_q ? ASCII_NONE : ascii_lkp;
            held_d.valid  = 1'b1;
            new_key_d     = 1'b1;
            press_count_d = press_count_q + 8'd1;
          end
          ext_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any partially received prefix sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      held_q        <= '0;
      new_key_q     <= 1'b0;
      press_count_q <= '0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      held_q        <= held_d;
      new_key_q     <= new_key_d;
      press_count_q <= press_count_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  assign key_code    = held_q.code;
  assign key_ext     = held_q.ext;
  assign key_ascii   = held_q.ascii;
  assign key_valid   = held_q.valid;
  assign new_key     = new_key_q;
  assign press_count = press_count_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Self-checking bench for kbd_scan_decoder: table vectors, corner sequences, random bytes vs model.
// Latency: n/a.
// Backpressure: the bench emulates the PS/2 receive FIFO and honours kb_nextdata_n.
module tb_kbd_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kb_data;
  logic       kb_ready;
  logic       kb_overflow;
  logic       kb_nextdata_n;
  logic [7:0] key_code;
  logic       key_ext;
  logic [7:0] key_ascii;
  logic       key_valid;
  logic       new_key;
  logic [7:0] press_count;
  logic       err_ovf;

  always #5 clk = ~clk;

  kbd_scan_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_ascii     (key_ascii),
    .key_valid     (key_valid),
    .new_key       (new_key),
    .press_count   (press_count),
    .err_ovf       (err_ovf)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- FIFO emulation and observers ----------------
  logic [7:0] fifo_q[$];
  int pop_cnt = 0;
  int adj_cnt = 0;
  int obs_pulses = 0;

  initial begin
    int cyc;
    int last_pop;
    cyc = 0;
    last_pop = -10;
    kb_ready = 1'b0;
    kb_data  = 8'h00;
    forever begin
      @(posedge clk);
      if (kb_nextdata_n === 1'b0) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_cnt++;
        if (last_pop == cyc - 1) adj_cnt++;
        last_pop = cyc;
      end
      cyc++;
      @(negedge clk);
      kb_ready = (fifo_q.size() > 0);
      kb_data  = kb_ready ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (new_key === 1'b1) obs_pulses++;
    end
  end

  // ---------------- behavioural reference model ----------------
  localparam logic [7:0] LETTER_CODES [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGIT_CODES [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ref_ascii(input logic [7:0] c);
    for (int i = 0; i < 26; i++) if (LETTER_CODES[i] == c) return 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) if (DIGIT_CODES[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  logic [7:0] m_code, m_ascii, m_cnt;
  logic       m_ext, m_valid, m_pend_ext, m_pend_brk;
  int         m_pulses;

  task automatic model_reset();
    m_code = 0; m_ascii = 0; m_cnt = 0; m_ext = 0; m_valid = 0;
    m_pend_ext = 0; m_pend_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic same;
    same = m_valid && (b == m_code) && (m_pend_ext == m_ext);
    if (b == 8'hE0) m_pend_ext = 1;
    else if (b == 8'hF0) m_pend_brk = 1;
    else if (m_pend_brk) begin
      if (same) m_valid = 0;
      m_pend_brk = 0;
      m_pend_ext = 0;
    end else begin
      if (!same) begin
        m_code  = b;
        m_ext   = m_pend_ext;
        m_ascii = m_pend_ext ? 8'h00 : ref_ascii(b);
        m_valid = 1;
        m_cnt   = m_cnt + 8'd1;
        m_pulses++;
      end
      m_pend_ext = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] code, input logic ext,
                             input logic [7:0] ascii, input logic valid, input logic [7:0] cnt);
    check($sformatf("%s.key_code", tag), 32'(key_code), 32'(code));
    check($sformatf("%s.key_ext", tag), 32'(key_ext), 32'(ext));
    check($sformatf("%s.key_ascii", tag), 32'(key_ascii), 32'(ascii));
    check($sformatf("%s.key_valid", tag), 32'(key_valid), 32'(valid));
    check($sformatf("%s.press_count", tag), 32'(press_count), 32'(cnt));
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
    model_byte(b);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || kb_ready) && n < budget) begin
      at_neg();
      n++;
    end
    if (n >= budget) begin
      tests++;
      fails++;
      $display("FAIL %s.drain_timeout: got %0d bytes left expected 0", tag, fifo_q.size());
    end
    repeat (4) at_neg();
  endtask

  task automatic do_reset();
    at_neg();
    rst = 1'b1;
    fifo_q.delete();
    model_reset();
    repeat (2) at_neg();
    rst = 1'b0;
    at_neg();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] code;
    logic       ext;
    logic [7:0] ascii;
    logic       valid;
    logic [7:0] cnt;
    int         pulses;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic [7:0] b0, b1, b2, input int n, input logic [7:0] code,
                         input logic ext, input logic [7:0] ascii, input logic valid,
                         input logic [7:0] cnt, input int pulses);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.n = n;
    v.code = code; v.ext = ext; v.ascii = ascii; v.valid = valid; v.cnt = cnt; v.pulses = pulses;
    vt.push_back(v);
  endtask

  localparam logic [7:0] RPOOL [12] = '{
    8'h1C, 8'h32, 8'h75, 8'h29, 8'h5A, 8'h16, 8'h76, 8'hE0, 8'hF0, 8'hF0, 8'hE0, 8'h1C};

  initial begin
    int p0, a0;
    rst = 1'b1;
    kb_overflow = 1'b0;
    model_reset();
    m_pulses = 0;

    // Reset state, and no pop strobe while reset holds even with data queued.
    repeat (2) at_neg();
    check_state("reset", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    check("reset.new_key", 32'(new_key), 32'd0);
    check("reset.err_ovf", 32'(err_ovf), 32'd0);
    fifo_q.push_back(8'h1C);
    repeat (3) at_neg();
    check("reset.nextdata_n_with_ready", 32'(kb_nextdata_n), 32'd1);
    check("reset.no_pop_in_reset", 32'(fifo_q.size()), 32'd1);
    do_reset();

    // Cumulative vectors: bytes, then expected held-key state and new_key pulses.
    add_vec(8'h1C, 0, 0, 1, 8'h1C, 0, 8'h61, 1, 8'd1, 1);
    add_vec(8'hF0, 8'h1C, 0, 2, 8'h1C, 0, 8'h61, 0, 8'd1, 0);
    add_vec(8'h1C, 8'h1C, 8'h1C, 3, 8'h1C, 0, 8'h61, 1, 8'd2, 1);
    add_vec(8'hE0, 8'h75, 0, 2, 8'h75, 1, 8'h00, 1, 8'd3, 1);
    add_vec(8'hE0, 8'hF0, 8'h75, 3, 8'h75, 1, 8'h00, 0, 8'd3, 0);
    add_vec(8'h29, 0, 0, 1, 8'h29, 0, 8'h20, 1, 8'd4, 1);
    add_vec(8'hF0, 8'h1C, 0, 2, 8'h29, 0, 8'h20, 1, 8'd4, 0);
    add_vec(8'h5A, 0, 0, 1, 8'h5A, 0, 8'h0D, 1, 8'd5, 1);
    add_vec(8'h45, 0, 0, 1, 8'h45, 0, 8'h30, 1, 8'd6, 1);
    add_vec(8'h76, 0, 0, 1, 8'h76, 0, 8'h00, 1, 8'd7, 1);
    add_vec(8'hE0, 8'h5A, 0, 2, 8'h5A, 1, 8'h00, 1, 8'd8, 1);
    add_vec(8'h5A, 0, 0, 1, 8'h5A, 0, 8'h0D, 1, 8'd9, 1);
    add_vec(8'h15, 0, 0, 1, 8'h15, 0, 8'h71, 1, 8'd10, 1);
    add_vec(8'h1A, 0, 0, 1, 8'h1A, 0, 8'h7A, 1, 8'd11, 1);

    for (int i = 0; i < vt.size(); i++) begin
      p0 = obs_pulses;
      send(vt[i].b0);
      if (vt[i].n > 1) send(vt[i].b1);
      if (vt[i].n > 2) send(vt[i].b2);
      drain($sformatf("vec%0d", i), 100);
      check_state($sformatf("vec%0d", i), vt[i].code, vt[i].ext, vt[i].ascii, vt[i].valid, vt[i].cnt);
      check($sformatf("vec%0d.new_key_pulses", i), 32'(obs_pulses - p0), 32'(vt[i].pulses));
    end

    // 256 press/release pairs wrap the counter; a mismatched release is ignored.
    do_reset();
    p0 = obs_pulses;
    for (int i = 0; i < 256; i++) begin
      send(8'h01 + 8'(i % 96));
      send(8'hF0);
      send(8'h01 + 8'(i % 96));
    end
    drain("wrap", 3000);
    check("wrap.press_count", 32'(press_count), 32'h00);
    check("wrap.pulses", 32'(obs_pulses - p0), 32'd256);
    check("wrap.key_valid", 32'(key_valid), 32'd0);
    send(8'h16);
    send(8'hF0);
    send(8'h1C);
    drain("wrap_tail", 100);
    check_state("wrap_tail", 8'h16, 1'b0, 8'h31, 1'b1, 8'h01);

    // Pending break prefix discarded by an asynchronous reset.
    do_reset();
    send(8'hF0);
    drain("brk_rst", 100);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("brk_rst.async_nextdata_n", 32'(kb_nextdata_n), 32'd1);
    model_reset();
    repeat (2) at_neg();
    rst = 1'b0;
    at_neg();
    send(8'h1C);
    drain("brk_rst", 100);
    check_state("brk_rst", 8'h1C, 1'b0, 8'h61, 1'b1, 8'h01);

    // Three queued bytes: three separated pops; overflow flag is sticky.
    do_reset();
    p0 = pop_cnt;
    a0 = adj_cnt;
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    repeat (12) at_neg();
    check("pop.count", 32'(pop_cnt - p0), 32'd3);
    check("pop.adjacent", 32'(adj_cnt - a0), 32'd0);
    check("pop.key_valid", 32'(key_valid), 32'd0);
    kb_overflow = 1'b1;
    at_neg();
    kb_overflow = 1'b0;
    at_neg();
    check("ovf.set", 32'(err_ovf), 32'd1);
    repeat (6) at_neg();
    check("ovf.sticky", 32'(err_ovf), 32'd1);
    do_reset();
    check("ovf.cleared", 32'(err_ovf), 32'd0);

    // Random byte streams compared with the reference model.
    for (int r = 0; r < 6; r++) begin
      p0 = obs_pulses;
      m_pulses = 0;
      for (int k = 0; k < 50; k++) send(RPOOL[$urandom_range(0, 11)]);
      drain($sformatf("rnd%0d", r), 400);
      check_state($sformatf("rnd%0d", r), m_code, m_ext, m_ascii, m_valid, m_cnt);
      check($sformatf("rnd%0d.new_key_pulses", r), 32'(obs_pulses - p0), 32'(m_pulses));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
